// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers (word offset): 0 TXDATA, 1 STATUS, 2 DIV, 3 CTRL.
// Optional feature macro: UART_TX_PERIPH_IRQ_EN (CTRL register + TX-done irq).
module uart_tx_periph #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wen_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o,
  output logic                  ready_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   bdiv_q, bdiv_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q;
  logic          ready_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [15:0]   div_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          irq_en_q;

  logic [PW-1:0] level;
  logic          full, empty, pop, push, accept, is_push, bit_end;
  logic [15:0]   div_eff;
  logic [7:0]    head;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end = (cnt_q == bdiv_q - 16'd1);

  // A push into a full FIFO waits for a pop; the popped slot is reused in that cycle.
  assign is_push = wen_i && (addr_i[1:0] == 2'd0) && be_i[0];
  assign accept  = req_i && !ready_q && !(is_push && full && !pop);
  assign push    = accept && is_push;

  // Read mux, evaluated at acceptance and held for the ready cycle only.
  always_comb begin
    rdata_d = 32'd0;
    if (accept && !wen_i) begin
      case (addr_i[1:0])
        2'd1:    rdata_d = {16'd0, 8'(level), 5'd0, (state_q != S_IDLE), full, empty};
        2'd2:    rdata_d = {16'd0, div_q};
`ifdef UART_TX_PERIPH_IRQ_EN
        2'd3:    rdata_d = {31'd0, irq_en_q};
`endif
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // Bus handshake and register writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      div_q    <= DIV_RESET;
      irq_en_q <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= rdata_d;
      if (accept && wen_i && addr_i[1:0] == 2'd2) begin
        if (be_i[0]) div_q[7:0]  <= wdata_i[7:0];
        if (be_i[1]) div_q[15:8] <= wdata_i[15:8];
      end
`ifdef UART_TX_PERIPH_IRQ_EN
      if (accept && wen_i && addr_i[1:0] == 2'd3 && be_i[0]) irq_en_q <= wdata_i[0];
`endif
    end
  end

  // FIFO pointers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i[7:0];
  end

  // TX FSM next state; divisor is latched per bit so DIV writes apply from the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bdiv_d  = bdiv_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = S_START;
          cnt_d   = 16'd0;
          bdiv_d  = div_eff;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = 16'd0;
          bdiv_d  = div_eff;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = 16'd0;
          bdiv_d  = div_eff;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (bit_end) begin
          // Chain straight into the next frame so there is no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
            cnt_d   = 16'd0;
            bdiv_d  = div_eff;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  // TX FSM state and registered serial line (reset drives the line high at once).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      bdiv_q  <= 16'd1;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bdiv_q  <= bdiv_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= (state_q == S_START) ? 1'b0 :
                 (state_q == S_DATA)  ? shift_q[0] : 1'b1;
    end
  end

`ifdef UART_TX_PERIPH_IRQ_EN
  logic irq_q;
  // TX-done level interrupt: enabled, nothing queued and the line idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_en_q && empty && (state_q == S_IDLE);
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Bits that are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = ^{addr_i, wdata_i[31:16], be_i[3:2], irq_en_q};

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: directed register/handshake checks plus
// randomized byte streams compared against an ideal 8N1 line model.
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [3:0]  addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready, tx, irq;

  int tests = 0;
  int fails = 0;
  logic [15:0] div_m;

  always #5 clk = ~clk;

  uart_tx_periph #(.ADDR_WIDTH(4), .FIFO_DEPTH(4), .DIV_RESET(16'd868)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .ready_o(ready),
    .tx_o(tx), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One bus transaction; returns data and request-to-ready latency in cycles.
  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    req = 1'b1; wen = w; addr = a; wdata = d; be = b;
    lat = 0; rd = 32'd0;
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (ready) begin
        rd = rdata;
        break;
      end
    end
    if (!ready) chk("bus_timeout", 32'(lat), 32'd0);
    req = 1'b0;
  endtask

  // DIV write with the byte-enable model applied to the reference copy.
  task automatic wr_div(input logic [31:0] d, input logic [3:0] b);
    logic [31:0] rd;
    int lat;
    bus(1'b1, 4'd2, d, b, rd, lat);
    if (b[0]) div_m[7:0]  = d[7:0];
    if (b[1]) div_m[15:8] = d[15:8];
  endtask

  // Ideal line: wait for a start bit, then each byte as 0,b0..b7,1 with div cycles per bit.
  task automatic chk_frames(input logic [7:0] q[$], input int div, input bit irq0);
    int n = 0;
    logic e;
    while (tx !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", 32'(n < 20000), 32'd1);
    foreach (q[i]) begin
      for (int j = 0; j < 10; j++) begin
        e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : q[i][j-1];
        for (int c = 0; c < div; c++) begin
          chk("tx_bit", 32'(tx), 32'(e));
          if (irq0) chk("irq_in_frame", 32'(irq), 32'd0);
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int lats[6];
    logic [7:0] q[$];
    logic [7:0] bytes[8];
    logic [3:0] bes[8];
    int n, d;

    req = 1'b0; wen = 1'b0; addr = 4'd0; wdata = 32'd0; be = 4'd0;
    rst_n = 1'b0;
    div_m = 16'd868;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    // STATUS after reset, latency and rdata drop-back.
    bus(1'b0, 4'd1, 32'd0, 4'hF, rd, lat);
    chk("status_rst", rd, 32'h1);
    chk("status_lat", 32'(lat), 32'd1);
    #10;
    chk("rdata_zero_after", rdata, 32'd0);
    chk("ready_pulse", 32'(ready), 32'd0);

    // DIV reset value and byte-enable masking; upper address bits alias.
    bus(1'b0, 4'd6, 32'd0, 4'hF, rd, lat);
    chk("div_rst_alias", rd, 32'd868);
    wr_div(32'hFFFF_FF03, 4'h1);
    bus(1'b0, 4'd2, 32'd0, 4'hF, rd, lat);
    chk("div_be_mask", rd, {16'd0, div_m});
    chk("div_be_const", rd, 32'h0000_0303);

    // TXDATA without be[0]: completes, no push.
    bus(1'b1, 4'd0, 32'h55, 4'hE, rd, lat);
    chk("nopush_lat", 32'(lat), 32'd1);
    bus(1'b0, 4'd1, 32'd0, 4'hF, rd, lat);
    chk("nopush_status", rd, 32'h1);
    bus(1'b0, 4'd0, 32'd0, 4'hF, rd, lat);
    chk("txdata_read0", rd, 32'd0);

    // Single frame 0xA5 at DIV=4, start bit two cycles after the ready cycle.
    wr_div(32'd4, 4'hF);
    bus(1'b1, 4'd0, 32'hA5, 4'hF, rd, lat);
    @(negedge clk); chk("fall_r0", 32'(tx), 32'd1);
    @(negedge clk); chk("fall_r1", 32'(tx), 32'd1);
    @(negedge clk); chk("fall_r2", 32'(tx), 32'd0);
    q = '{8'hA5};
    chk_frames(q, 4, 1'b0);
    chk("idle_after", 32'(tx), 32'd1);
    bus(1'b0, 4'd1, 32'd0, 4'hF, rd, lat);
    chk("status_done", rd, 32'h1);

    // Burst of 6 at DIV=2: the sixth push finds the FIFO full and stalls.
    wr_div(32'd2, 4'hF);
    q = {};
    for (int i = 0; i < 6; i++) begin
      bytes[i] = 8'($urandom);
      q.push_back(bytes[i]);
    end
    fork
      for (int i = 0; i < 6; i++) bus(1'b1, 4'd0, {24'd0, bytes[i]}, 4'h1, rd, lats[i]);
      chk_frames(q, 2, 1'b0);
    join
    for (int i = 0; i < 4; i++) chk("burst_lat", 32'(lats[i]), 32'd1);
    chk("burst_stall", 32'(lats[5] > 1), 32'd1);
    chk("burst_idle", 32'(tx), 32'd1);

    // Randomized streams: random divisor, count, data and byte enables.
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(1, 3);
      wr_div(32'(d), 4'h3);
      n = $urandom_range(1, 7);
      q = {};
      for (int i = 0; i < n; i++) begin
        bytes[i] = 8'($urandom);
        bes[i]   = 4'($urandom);
        if (i == 0) bes[i][0] = 1'b1;
        if (bes[i][0]) q.push_back(bytes[i]);
      end
      fork
        for (int i = 0; i < n; i++) bus(1'b1, 4'd0, {24'd0, bytes[i]}, bes[i], rd, lat);
        chk_frames(q, d, 1'b0);
      join
      chk("rand_idle", 32'(tx), 32'd1);
      bus(1'b0, 4'd1, 32'd0, 4'hF, rd, lat);
      chk("rand_status", rd, 32'h1);
    end

    // DIV=0 behaves as one cycle per bit.
    wr_div(32'd0, 4'hF);
    bytes[0] = 8'($urandom);
    q = '{bytes[0]};
    fork
      bus(1'b1, 4'd0, {24'd0, bytes[0]}, 4'hF, rd, lat);
      chk_frames(q, 1, 1'b0);
    join
    chk("div0_idle", 32'(tx), 32'd1);

    // Asynchronous reset in the middle of a data bit.
    wr_div(32'd4, 4'hF);
    bus(1'b1, 4'd0, 32'h00, 4'hF, rd, lat);
    bus(1'b1, 4'd0, 32'h00, 4'hF, rd, lat);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("pre_rst_low", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_tx", 32'(tx), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    div_m = 16'd868;
    bus(1'b0, 4'd1, 32'd0, 4'hF, rd, lat);
    chk("post_rst_status", rd, 32'h1);
    bus(1'b0, 4'd2, 32'd0, 4'hF, rd, lat);
    chk("post_rst_div", rd, {16'd0, div_m});
    repeat (50) @(negedge clk);
    chk("post_rst_line", 32'(tx), 32'd1);

`ifdef UART_TX_PERIPH_IRQ_EN
    wr_div(32'd1, 4'hF);
    bus(1'b1, 4'd3, 32'd1, 4'hF, rd, lat);
    bus(1'b0, 4'd3, 32'd0, 4'hF, rd, lat);
    chk("ctrl_read", rd, 32'd1);
    bytes[0] = 8'($urandom);
    q = '{bytes[0]};
    fork
      bus(1'b1, 4'd0, {24'd0, bytes[0]}, 4'hF, rd, lat);
      chk_frames(q, 1, 1'b1);
    join
    chk("irq_after_stop", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_level", 32'(irq), 32'd1);
    bus(1'b1, 4'd3, 32'd0, 4'hF, rd, lat);
    #10;
    chk("irq_cleared", 32'(irq), 32'd0);
`else
    bus(1'b1, 4'd3, 32'd1, 4'hF, rd, lat);
    bus(1'b0, 4'd3, 32'd0, 4'hF, rd, lat);
    chk("ctrl_absent", rd, 32'd0);
    chk("irq_absent", 32'(irq), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
